// File: rtl/data_sramlike_if.sv
// Data-side sram-like bus between the core's mem stage and a data responder.
interface data_sramlike_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        busy;

    modport master (
        output req, wr, size, sel, addr, wdata,
        input  addr_ok, data_ok, rdata, busy
    );

    modport slave (
        input  req, wr, size, sel, addr, wdata,
        output addr_ok, data_ok, rdata, busy
    );
endinterface

// File: rtl/data_sramlike_responder.sv
// Responder end of the data sram-like bus: word-addressed RAM with byte-lane
// writes, an in-order tracking FIFO and a fixed accept-to-data_ok latency.
module data_sramlike_responder #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned ADDR_W  = 8
) (
    input  logic            clk,
    input  logic            rst,
    data_sramlike_if.slave  bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NSLOT = 2 ** PTR_W;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [3:0]  CD_INIT = 4'(LATENCY - 1);

    logic [31:0]       mem [2 ** ADDR_W];

    logic              entValid [NSLOT];
    logic              entWr    [NSLOT];
    logic [31:0]       entData  [NSLOT];
    logic [3:0]        entCnt   [NSLOT];

    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [CNT_W-1:0]  count;

    logic [ADDR_W-1:0] idx;
    logic              accept;
    logic              headDone;
    logic              unusedBits;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign idx        = bus.addr[ADDR_W+1:2];
    assign unusedBits = ^{bus.size, bus.addr[31:ADDR_W+2], bus.addr[1:0]};

    // Acceptance depends only on occupancy, so there is no path from data_ok.
    assign bus.addr_ok = ~rst && (count < CNT_W'(DEPTH));
    assign accept      = bus.req && bus.addr_ok;

    // Fixed latency means the head is always the oldest entry to reach zero.
    assign headDone    = entValid[rdPtr] && (entCnt[rdPtr] == '0);

    assign bus.data_ok = ~rst && headDone;
    assign bus.rdata   = (bus.data_ok && !entWr[rdPtr]) ? entData[rdPtr] : '0;
    assign bus.busy    = ~rst && (count != '0);

    // RAM byte-lane writes on accept; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (accept && bus.wr) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (bus.sel[i]) begin
                    mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    // Tracking FIFO: push on accept, count down every entry, pop the head at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int unsigned i = 0; i < NSLOT; i++) begin
                entValid[i] <= 1'b0;
            end
        end else begin
            for (int unsigned i = 0; i < NSLOT; i++) begin
                if (entValid[i] && (entCnt[i] != '0)) begin
                    entCnt[i] <= entCnt[i] - 4'd1;
                end
            end
            if (headDone) begin
                entValid[rdPtr] <= 1'b0;
                rdPtr           <= nextPtr(rdPtr);
            end
            // A push only targets a free slot, so it never collides with the pop.
            if (accept) begin
                entValid[wrPtr] <= 1'b1;
                entWr[wrPtr]    <= bus.wr;
                entData[wrPtr]  <= bus.wr ? '0 : mem[idx];
                entCnt[wrPtr]   <= CD_INIT;
                wrPtr           <= nextPtr(wrPtr);
            end
            case ({accept, headDone})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_data_sramlike_responder.sv
// Bench for data_sramlike_responder: two instances (LATENCY 2/DEPTH 2 and
// LATENCY 1/DEPTH 4) checked every cycle against a transaction-level model.
module tb_data_sramlike_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        reqV   [2];
    logic        wrV    [2];
    logic [1:0]  sizeV  [2];
    logic [3:0]  selV   [2];
    logic [31:0] addrV  [2];
    logic [31:0] wdataV [2];
    logic        aokO   [2];
    logic        dokO   [2];
    logic        busyO  [2];
    logic [31:0] rdO    [2];

    data_sramlike_if bus0 ();
    data_sramlike_if bus1 ();

    assign bus0.req = reqV[0];  assign bus0.wr = wrV[0];  assign bus0.size = sizeV[0];
    assign bus0.sel = selV[0];  assign bus0.addr = addrV[0];  assign bus0.wdata = wdataV[0];
    assign bus1.req = reqV[1];  assign bus1.wr = wrV[1];  assign bus1.size = sizeV[1];
    assign bus1.sel = selV[1];  assign bus1.addr = addrV[1];  assign bus1.wdata = wdataV[1];
    assign aokO[0] = bus0.addr_ok;  assign dokO[0] = bus0.data_ok;
    assign rdO[0]  = bus0.rdata;    assign busyO[0] = bus0.busy;
    assign aokO[1] = bus1.addr_ok;  assign dokO[1] = bus1.data_ok;
    assign rdO[1]  = bus1.rdata;    assign busyO[1] = bus1.busy;

    data_sramlike_responder #(.LATENCY(2), .DEPTH(2), .ADDR_W(8)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    data_sramlike_responder #(.LATENCY(1), .DEPTH(4), .ADDR_W(8)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    typedef struct {
        int          dut;
        int          due;
        bit          wr;
        logic [31:0] data;
    } exp_t;

    exp_t        pend [$];
    logic [31:0] mdl [2][256];
    int          cyc;
    int          checks;
    int          errors;
    bit          accepted [2];
    logic [31:0] lastRd   [2];
    int          dokCnt   [2];
    logic [7:0]  aokHist  [2];
    logic [7:0]  dokHist  [2];

    function automatic int latOf(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic int depOf(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setIdle(input int k);
        reqV[k] = 1'b0; wrV[k] = 1'b0; sizeV[k] = 2'd2;
        selV[k] = 4'h0; addrV[k] = '0; wdataV[k] = '0;
    endtask

    // One clock cycle: compare both DUTs with the model, then advance the model.
    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            int          n;
            int          head;
            bit          eAok;
            bit          eDok;
            bit          eBusy;
            logic [31:0] eRd;
            logic [7:0]  idx;
            n = 0;
            head = -1;
            foreach (pend[i]) begin
                if (pend[i].dut == k) begin
                    if (head < 0) head = i;
                    n++;
                end
            end
            eAok  = !rst && (n < depOf(k));
            eDok  = !rst && (n > 0) && (pend[head].due == cyc);
            eRd   = (eDok && !pend[head].wr) ? pend[head].data : 32'h0;
            eBusy = !rst && (n > 0);
            chk($sformatf("addr_ok%0d@%0d", k, cyc), 32'(aokO[k]), 32'(eAok));
            chk($sformatf("data_ok%0d@%0d", k, cyc), 32'(dokO[k]), 32'(eDok));
            chk($sformatf("rdata%0d@%0d", k, cyc), rdO[k], eRd);
            chk($sformatf("busy%0d@%0d", k, cyc), 32'(busyO[k]), 32'(eBusy));
            aokHist[k] = {aokHist[k][6:0], aokO[k]};
            dokHist[k] = {dokHist[k][6:0], dokO[k]};
            if (dokO[k]) dokCnt[k]++;
            if (eDok && !pend[head].wr) lastRd[k] = rdO[k];
            accepted[k] = 1'b0;
            if (rst) begin
                for (int i = pend.size() - 1; i >= 0; i--) begin
                    if (pend[i].dut == k) pend.delete(i);
                end
            end else begin
                if (eDok) pend.delete(head);
                if (reqV[k] && eAok) begin
                    idx = addrV[k][9:2];
                    if (wrV[k]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (selV[k][b]) mdl[k][idx][8*b +: 8] = wdataV[k][8*b +: 8];
                        end
                        pend.push_back('{k, cyc + latOf(k), 1'b1, 32'h0});
                    end else begin
                        pend.push_back('{k, cyc + latOf(k), 1'b0, mdl[k][idx]});
                    end
                    accepted[k] = 1'b1;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int k, input bit w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] d);
        reqV[k] = 1'b1; wrV[k] = w; selV[k] = s; addrV[k] = a; wdataV[k] = d;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (accepted[k]) break;
        end
        chk($sformatf("accept_timeout%0d", k), 32'(accepted[k]), 32'd1);
        setIdle(k);
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && pend.size() != 0; t++) tick();
        chk("drain_busy", 32'({busyO[0], busyO[1]}), 32'd0);
    endtask

    initial begin
        int          n0;
        logic [31:0] r;
        logic [31:0] r2;
        checks = 0; errors = 0; cyc = 0;
        dokCnt[0] = 0; dokCnt[1] = 0;
        aokHist[0] = '0; aokHist[1] = '0; dokHist[0] = '0; dokHist[1] = '0;
        lastRd[0] = '0; lastRd[1] = '0;
        setIdle(0); setIdle(1);

        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Known contents for word indices 0..15 in both RAMs.
        for (int i = 0; i < 16; i++) begin
            issue(0, 1'b1, 4'hF, 32'(i * 4), $urandom);
            issue(1, 1'b1, 4'hF, 32'(i * 4), $urandom);
        end
        drain();

        // Word write then read, each completing two cycles after accept.
        issue(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        tick(); tick();
        chk("wr_latency", 32'(dokHist[0][1:0]), 32'b01);
        issue(0, 1'b0, 4'h0, 32'h10, 32'h0);
        tick(); tick();
        chk("rd_latency", 32'(dokHist[0][1:0]), 32'b01);
        chk("rd_deadbeef", lastRd[0], 32'hDEADBEEF);

        // Byte-lane merge.
        issue(0, 1'b1, 4'hF, 32'h20, 32'h11223344);
        issue(0, 1'b1, 4'b0100, 32'h20, 32'h00AA0000);
        issue(0, 1'b0, 4'h0, 32'h20, 32'h0);
        drain();
        chk("byte_merge", lastRd[0], 32'h11AA3344);

        // Held req on the DEPTH=2 instance: addr_ok 1,1,0,1.
        n0 = dokCnt[0];
        reqV[0] = 1'b1; wrV[0] = 1'b0; addrV[0] = 32'h10;
        for (int i = 0; i < 4; i++) tick();
        setIdle(0);
        chk("held_aok_pattern", 32'(aokHist[0][3:0]), 32'b1101);
        drain();
        chk("held_dok_count", 32'(dokCnt[0] - n0), 32'd3);

        // LATENCY=1: four consecutive reads give four consecutive data_ok.
        reqV[1] = 1'b1; wrV[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addrV[1] = 32'(i * 4);
            tick();
        end
        setIdle(1);
        tick();
        chk("lat1_dok_stream", 32'(dokHist[1][4:0]), 32'b01111);
        drain();

        // Reset with two reads outstanding discards them; RAM survives.
        issue(0, 1'b1, 4'hF, 32'h30, 32'hCAFEF00D);
        drain();
        n0 = dokCnt[0];
        reqV[0] = 1'b1; wrV[0] = 1'b0; addrV[0] = 32'h20;
        tick(); tick();
        setIdle(0);
        rst = 1'b1;
        tick();
        chk("rst_cycle_aok", 32'(aokHist[0][0]), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_aok", 32'(aokHist[0][0]), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        chk("rst_no_dok", 32'(dokCnt[0] - n0), 32'd0);
        issue(0, 1'b0, 4'h0, 32'h30, 32'h0);
        drain();
        chk("ram_survives_rst", lastRd[0], 32'hCAFEF00D);

        // Upper address bits alias; sel=0 write completes without changing RAM.
        issue(0, 1'b1, 4'hF, 32'h0000_0004, 32'h0000_0055);
        issue(0, 1'b0, 4'h0, 32'h0000_0404, 32'h0);
        drain();
        chk("alias_read", lastRd[0], 32'h0000_0055);
        issue(0, 1'b1, 4'h0, 32'h0000_0004, 32'hFFFF_FFFF);
        issue(0, 1'b0, 4'h0, 32'h0000_0004, 32'h0);
        drain();
        chk("sel0_noop", lastRd[0], 32'h0000_0055);

        // Randomized traffic on both instances with occasional resets.
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 2; k++) begin
                r  = $urandom;
                r2 = $urandom;
                reqV[k]   = (r[3:0] < 4'd11);
                wrV[k]    = r[4];
                selV[k]   = r[8:5];
                sizeV[k]  = r[10:9];
                addrV[k]  = {r2[21:0], 4'b0000, r[14:11], r[16:15]};
                wdataV[k] = $urandom;
            end
            r   = $urandom;
            rst = (r[5:0] == 6'd0);
            tick();
        end
        rst = 1'b0;
        setIdle(0); setIdle(1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_sramlike_responder.md
Name: data_sramlike_responder

Overview:
- Responder end of the CPU data-side sram-like interface: accepts requests (addr/size/byte-select/wdata), backs them with an internal word-addressed RAM, and returns in-order data_ok/rdata after a fixed latency.
- Used as the data-memory model behind the core's mem stage in unit and SoC-lite benches. Also used as the behavioural target when the cache/AXI bridge is removed.
- Supports multiple outstanding transactions, so the core's stallreq_from_mem path is exercised realistically.

Parameters:
- LATENCY, 2, cycles from the accept edge to the data_ok pulse; legal range 1..15.
- DEPTH, 2, maximum outstanding (accepted, not yet data_ok) transactions; legal range 1..4.
- ADDR_W, 8, word-index width; RAM holds 2^ADDR_W 32-bit words.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- req  in  1  request valid.
- wr  in  1  1 = write, 0 = read.
- size  in  2  0 = byte, 1 = half, 2 = word; informational only, sel governs writes.
- sel  in  4  byte-lane write enables, lane i = wdata[8i+7:8i].
- addr  in  32  byte address; word index = addr[ADDR_W+1:2]; upper bits ignored (aliasing).
- wdata  in  32  write data, already lane-aligned by the core.
- addr_ok  out  1  request accepted this cycle when req && addr_ok.
- data_ok  out  1  one-cycle completion pulse, one per accepted transaction, in order.
- rdata  out  32  read word; valid only while data_ok is high for a read.
- busy  out  1  at least one transaction is outstanding.

Behaviour:
- Reset values:
  - addr_ok = 0 during the rst cycle, 1 from the first cycle after.
  - data_ok = 0, rdata = 0, busy = 0.
  - All tracking entries are invalid.
- RAM contents are not reset; they persist across rst.
- addr_ok = ~rst_q && (count < DEPTH), registered-free. It depends only on occupancy, never on that cycle's completion, so there is no comb path from data_ok to addr_ok.
- Accept (req && addr_ok at posedge):
  - Write: RAM[idx] bytes with sel[i]=1 are updated at this edge. Lanes with sel=0 are unchanged. sel=0 is a legal no-op write that still completes.
  - Read: the entry captures RAM[idx] at this edge, after any same-edge write from the same request (none for a read). Read-after-write ordering therefore follows acceptance order.
  - The entry is pushed into the tracking FIFO (circular, DEPTH entries: wr flag, 32-bit data, 4-bit countdown initialised to LATENCY-1). Write pointer wraps modulo DEPTH.
- Countdown: each valid entry decrements each cycle until 0. The head entry with countdown 0 drives data_ok=1 and is popped that cycle. Fixed LATENCY guarantees the head is always the first to reach 0.
- Latency: data_ok is high in cycle A+LATENCY for a request accepted in cycle A. LATENCY=1 gives back-to-back accepts back-to-back data_ok pulses, full throughput.
- rdata = captured word when the popped entry is a read; 0 for a write completion or when data_ok=0.
- Simultaneous push and pop: count unchanged. With count==DEPTH, addr_ok stays 0 in that cycle even though a pop occurs; the push is taken next cycle.
- Full: addr_ok=0 and req is ignored (no side effect, no RAM write). The requester must hold req.
- Empty: busy=0, data_ok=0.
- rst mid-operation: all outstanding entries are discarded and no data_ok is produced for them. RAM writes already accepted remain.
- size is not checked; misaligned addresses are not flagged (the core raises AdEL/AdES before issuing).

Test Plan:
- Reset, then word write addr=0x10 sel=4'hF wdata=0xDEADBEEF, then read 0x10 -> write data_ok at A+2; read data_ok at A'+2 with rdata=0xDEADBEEF.
- Byte merge: write 0x11223344 to 0x20 (sel=F), then sel=4'b0100 wdata=0x00AA0000, read 0x20 -> rdata=0x11AA3344.
- Back-to-back reads with req held, DEPTH=2, LATENCY=2 -> addr_ok pattern 1,1,0 then 1 after the first data_ok. Exactly one data_ok per request, in order, busy high throughout.
- LATENCY=1, four reads on consecutive cycles -> four consecutive data_ok pulses, rdata matches each address in order.
- Issue two reads, assert rst one cycle after the second accept -> no data_ok after rst. addr_ok=0 in the rst cycle, 1 after. A prior write to 0x30 is still readable.
- Alias check, ADDR_W=8: write 0x55 to addr 0x0000_0004, read addr 0x0000_0404 -> rdata=0x00000055.
